conv1_acc_requant: RTL and testbench

- Downstream stage of the conv1 fixed-point multiplier (9-bit unsigned pixel × 14-bit signed weight → 23-bit signed product).
- Accumulates KERNEL_TAPS products per output pixel, seeded with a per-output bias.
- Rounds and right-shifts the sum back to activation scale, then saturates to OUT_WIDTH.
- Delivers one requantized activation per window over a valid/ready handshake.

---
 rtl/conv1_acc_requant.sv | 153 +++++++++++++++
 tb/tb_conv1_acc_requant.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv1_acc_requant.sv
// conv1_acc_requant
//   Accumulates KERNEL_TAPS signed products per output pixel, seeded with a
//   per-output bias. The sum is then rounded (half toward +inf), shifted
//   right by FRAC_SHIFT, saturated to OUT_WIDTH and delivered over a
//   valid/ready handshake.
//
//   Optional build macro: CONV1_ACC_RELU_EN
//     defined   -> negative saturated results are replaced by 0
//     undefined -> signed saturated result passes through unchanged
//
// Ports
//   ap_clk      clock, rising edge
//   ap_rst_n    asynchronous active-low reset
//   prod_valid  product present on prod_data
//   prod_ready  block accepts a product this cycle (from state only)
//   prod_data   signed product, PROD_WIDTH bits
//   bias        signed bias at accumulator scale, sampled with the first tap
//   out_valid   result present on out_data
//   out_ready   consumer accepts the result
//   out_data    signed requantized result, OUT_WIDTH bits
//   busy        high unless idle at the start of a window
//
// state | meaning
// ------+-------------------------------------------------------------
// S_ACC | accepting taps; tap_cnt counts taps already taken in window
// S_FIN | round, shift, saturate the finished sum into out_data
// S_OUT | holding the result until out_ready
module conv1_acc_requant #(
    parameter int PROD_WIDTH  = 23,
    parameter int ACC_WIDTH   = 32,
    parameter int BIAS_WIDTH  = 16,
    parameter int KERNEL_TAPS = 25,
    parameter int FRAC_SHIFT  = 8,
    parameter int OUT_WIDTH   = 16
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         prod_valid,
    output logic                         prod_ready,
    input  logic signed [PROD_WIDTH-1:0] prod_data,
    input  logic signed [BIAS_WIDTH-1:0] bias,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [OUT_WIDTH-1:0]  out_data,
    output logic                         busy
);

    localparam int CNT_W = (KERNEL_TAPS > 1) ? $clog2(KERNEL_TAPS) : 1;
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(KERNEL_TAPS - 1);

    // Rounding and clamp constants live at ACC_WIDTH+1 bits so the rounding
    // add can never wrap.
    localparam logic signed [ACC_WIDTH:0] HALF =
        {{ACC_WIDTH{1'b0}}, 1'b1} << (FRAC_SHIFT - 1);
    localparam logic signed [ACC_WIDTH:0] OUT_MAX =
        {{(ACC_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] OUT_MIN =
        {{(ACC_WIDTH - OUT_WIDTH + 2){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        S_ACC = 2'd0,
        S_FIN = 2'd1,
        S_OUT = 2'd2
    } state_t;

    state_t                        state;
    logic [CNT_W-1:0]              tap_cnt;
    logic signed [ACC_WIDTH-1:0]   acc;

    logic signed [ACC_WIDTH-1:0]   prod_ext;
    logic signed [ACC_WIDTH-1:0]   bias_ext;
    logic signed [ACC_WIDTH-1:0]   acc_next;
    logic signed [ACC_WIDTH:0]     rnd_sum;
    logic signed [ACC_WIDTH:0]     rnd_shift;
    logic signed [OUT_WIDTH-1:0]   sat;
    logic signed [OUT_WIDTH-1:0]   result;

    assign prod_ready = (state == S_ACC);
    assign busy       = (state != S_ACC) || (tap_cnt != '0);

    always_comb begin
        prod_ext = {{(ACC_WIDTH - PROD_WIDTH){prod_data[PROD_WIDTH-1]}}, prod_data};
        bias_ext = {{(ACC_WIDTH - BIAS_WIDTH){bias[BIAS_WIDTH-1]}}, bias};
        // The first tap of a window restarts from the bias, not from acc.
        if (tap_cnt == '0) begin
            acc_next = bias_ext + prod_ext;
        end else begin
            acc_next = acc + prod_ext;
        end
    end

    always_comb begin
        rnd_sum   = {acc[ACC_WIDTH-1], acc} + HALF;
        rnd_shift = rnd_sum >>> FRAC_SHIFT;
        if (rnd_shift > OUT_MAX) begin
            sat = OUT_MAX[OUT_WIDTH-1:0];
        end else if (rnd_shift < OUT_MIN) begin
            sat = OUT_MIN[OUT_WIDTH-1:0];
        end else begin
            sat = rnd_shift[OUT_WIDTH-1:0];
        end
`ifdef CONV1_ACC_RELU_EN
        if (sat[OUT_WIDTH-1]) begin
            result = '0;
        end else begin
            result = sat;
        end
`else
        result = sat;
`endif
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state     <= S_ACC;
            tap_cnt   <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                S_ACC: begin
                    if (prod_valid) begin
                        acc <= acc_next;
                        if (tap_cnt == LAST_TAP) begin
                            tap_cnt <= '0;
                            state   <= S_FIN;
                        end else begin
                            tap_cnt <= tap_cnt + CNT_W'(1);
                        end
                    end
                end
                S_FIN: begin
                    out_data  <= result;
                    out_valid <= 1'b1;
                    state     <= S_OUT;
                end
                S_OUT: begin
                    // out_data is left as-is after the handshake.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        state     <= S_ACC;
                    end
                end
                default: begin
                    state <= S_ACC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv1_acc_requant.sv
module tb_conv1_acc_requant;

    localparam int PW = 23;
    localparam int BW = 16;
    localparam int OW = 16;
    localparam int TAPS = 25;

    logic                 ap_clk;
    logic                 ap_rst_n;
    logic                 prod_valid;
    logic                 prod_ready;
    logic signed [PW-1:0] prod_data;
    logic signed [BW-1:0] bias;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] out_data;
    logic                 busy;

    int vectors;
    int miscompares;
    int cyc;
    int taps_q[$];

    conv1_acc_requant dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .prod_data  (prod_data),
        .bias       (bias),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    initial cyc = 0;
    always @(posedge ap_clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // Reference: exact integer sum, floor((sum + 128) / 256), clamp, optional ReLU.
    function automatic longint model(input int b);
        longint s;
        longint r;
        s = b;
        foreach (taps_q[i]) s = s + taps_q[i];
        r = (s + 128) >>> 8;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
`ifdef CONV1_ACC_RELU_EN
        if (r < 0) r = 0;
`endif
        return r;
    endfunction

    function automatic int rnd_prod();
        return int'($urandom_range(0, 8388607)) - 4194304;
    endfunction

    task automatic fill_const(input int v);
        taps_q = {};
        for (int i = 0; i < TAPS; i++) taps_q.push_back(v);
    endtask

    // Feeds taps_q as one window (with random idle gaps), then checks the
    // result latency, the backpressure hold and the handshake.
    task automatic run_window(input int b, input int gap_pct, input int hold,
                              input string tag, output int first_cyc);
        longint exp;
        exp = model(b);
        first_cyc = 0;
        for (int i = 0; i < TAPS; i++) begin
            while (int'($urandom_range(0, 99)) < gap_pct) begin
                prod_valid = 1'b0;
                prod_data  = PW'(rnd_prod());
                bias       = BW'($urandom);
                tick();
            end
            prod_valid = 1'b1;
            prod_data  = PW'(taps_q[i]);
            bias       = (i == 0) ? BW'(b) : BW'($urandom);
            tick();
            if (i == 0) begin
                first_cyc = cyc;
                check({tag, "_busy_first"}, busy, 1);
            end
        end
        prod_valid = 1'($urandom_range(0, 1));
        prod_data  = PW'(rnd_prod());
        out_ready  = (hold == 0);
        check({tag, "_fin_ready"}, prod_ready, 0);
        check({tag, "_fin_valid"}, out_valid, 0);
        tick();
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_data"}, out_data, exp);
        check({tag, "_out_ready"}, prod_ready, 0);
        for (int h = 0; h < hold; h++) begin
            prod_valid = 1'b1;
            prod_data  = PW'(rnd_prod());
            tick();
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_data"}, out_data, exp);
            check({tag, "_hold_pready"}, prod_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        prod_valid = 1'b0;
        check({tag, "_hs_valid"}, out_valid, 0);
        check({tag, "_hs_pready"}, prod_ready, 1);
        check({tag, "_hs_busy"}, busy, 0);
        check({tag, "_hs_data"}, out_data, exp);
    endtask

    initial begin
        int c0;
        int c1;
        int c2;
        vectors     = 0;
        miscompares = 0;
        ap_rst_n    = 1'b0;
        prod_valid  = 1'b0;
        prod_data   = '0;
        bias        = '0;
        out_ready   = 1'b1;

        #12;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_pready", prod_ready, 1);
        #5 ap_rst_n = 1'b1;
        tick();

        // basic sum
        fill_const(256);
        run_window(0, 0, 0, "basic", c0);

        // rounding boundaries
        fill_const(0); taps_q[0] = 128;
        run_window(0, 0, 0, "rnd_p128", c0);
        fill_const(0); taps_q[0] = 127;
        run_window(0, 0, 0, "rnd_p127", c0);
        fill_const(0); taps_q[0] = -129;
        run_window(0, 0, 0, "rnd_m129", c0);
        fill_const(0);
        run_window(-128, 0, 0, "rnd_bias", c0);

        // saturation
        fill_const(4194303);
        run_window(0, 0, 0, "sat_pos", c0);
        fill_const(-4194304);
        run_window(0, 0, 0, "sat_neg", c0);

        // backpressure, then a clean window right after
        fill_const(256);
        run_window(0, 0, 10, "bp", c0);
        fill_const(256);
        run_window(256, 0, 0, "after_bp", c0);

        // random data, random gaps, random backpressure
        for (int w = 0; w < 8; w++) begin
            int b;
            taps_q = {};
            for (int i = 0; i < TAPS; i++) taps_q.push_back(rnd_prod() >>> $urandom_range(0, 12));
            b = int'($urandom_range(0, 65535)) - 32768;
            run_window(b, 30, int'($urandom_range(0, 3)), "rand", c0);
        end

        // reset mid-window
        for (int i = 0; i < 10; i++) begin
            prod_valid = 1'b1;
            prod_data  = PW'(1000);
            bias       = '0;
            tick();
        end
        #2 ap_rst_n = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_data", out_data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_pready", prod_ready, 1);
        prod_valid = 1'b0;
        #2 ap_rst_n = 1'b1;
        tick();
        fill_const(256);
        run_window(512, 0, 0, "post_rst", c0);

        // back-to-back windows, out_ready held high
        fill_const(256);
        run_window(0, 0, 0, "b2b0", c0);
        run_window(256, 0, 0, "b2b1", c1);
        run_window(-256, 0, 0, "b2b2", c2);
        check("period01", c1 - c0, 27);
        check("period12", c2 - c1, 27);

        // reset while a result is pending
        for (int i = 0; i < TAPS; i++) begin
            prod_valid = 1'b1;
            prod_data  = PW'(256);
            bias       = '0;
            tick();
        end
        prod_valid = 1'b0;
        out_ready  = 1'b0;
        tick();
        check("outrst_pre_valid", out_valid, 1);
        #2 ap_rst_n = 1'b0;
        #1;
        check("outrst_valid", out_valid, 0);
        check("outrst_data", out_data, 0);
        check("outrst_busy", busy, 0);
        #2 ap_rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        fill_const(256);
        run_window(0, 0, 0, "final", c0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
